// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csr_trap_ctrl : machine-mode trap / MRET sequencer driving the CSR |
// |                 command port and the fetch PC redirect.            |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module csr_trap_ctrl #(
  parameter int XLEN        = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            exc_valid,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            irq_valid,
  input  logic [4:0]      irq_cause,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            mret_valid,
  output logic            trap_ack,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [11:0]     csr_index,
  output logic [2:0]      csr_opcode,
  output logic            csr_ren,
  output logic            csr_wen,
  output logic [XLEN-1:0] csr_reg_val,
  input  logic [XLEN-1:0] csr_val
);

  localparam logic [11:0] c_addr_mstatus = 12'h300;
  localparam logic [11:0] c_addr_mtvec   = 12'h305;
  localparam logic [11:0] c_addr_mepc    = 12'h341;
  localparam logic [11:0] c_addr_mcause  = 12'h342;
  localparam logic [11:0] c_addr_mtval   = 12'h343;
  localparam logic [2:0]  c_op_nop       = 3'b000;
  localparam logic [2:0]  c_op_csrrw     = 3'b001;
  localparam logic [2:0]  c_op_csrrs     = 3'b010;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_MSTATUS, S_WR_MSTATUS, S_WR_MEPC, S_WR_MCAUSE,
    S_WR_MTVAL, S_RD_MTVEC, S_RD_MEPC, S_REDIRECT
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_is_irq, r_is_mret;
  logic [4:0]        r_cause;
  logic [XLEN-1:0]   r_pc, r_tval, r_ms, r_target;
  logic [XLEN-1:0]   w_base, w_target, w_ms_trap, w_ms_mret, w_mcause;

  // Same target path serves mtvec (trap) and mepc (MRET); only mtvec can vector.
  always_comb begin
    w_base   = {csr_val[XLEN-1:2], 2'b00};
    w_target = w_base;
    if (VECTORED_EN && r_state == S_RD_MTVEC && r_is_irq && csr_val[1:0] == 2'b01)
      w_target = w_base + {{(XLEN-7){1'b0}}, r_cause, 2'b00};
  end

  always_comb begin
    w_ms_trap        = r_ms;
    w_ms_trap[7]     = r_ms[3];
    w_ms_trap[3]     = 1'b0;
    w_ms_trap[12:11] = 2'b11;
    w_ms_mret        = r_ms;
    w_ms_mret[3]     = r_ms[7];
    w_ms_mret[7]     = 1'b1;
    w_ms_mret[12:11] = 2'b11;
    w_mcause         = '0;
    w_mcause[XLEN-1] = r_is_irq;
    w_mcause[4:0]    = r_cause;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= S_IDLE;
      r_is_irq  <= 1'b0;
      r_is_mret <= 1'b0;
      r_cause   <= 5'd0;
      r_pc      <= '0;
      r_tval    <= '0;
      r_ms      <= '0;
      r_target  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (exc_valid) begin
            r_is_irq  <= 1'b0;
            r_is_mret <= 1'b0;
            r_cause   <= exc_cause;
            r_pc      <= {exc_pc[XLEN-1:2], 2'b00};
            r_tval    <= exc_tval;
          end else if (irq_valid) begin
            r_is_irq  <= 1'b1;
            r_is_mret <= 1'b0;
            r_cause   <= irq_cause;
            r_pc      <= {irq_pc[XLEN-1:2], 2'b00};
            r_tval    <= '0;
          end else if (mret_valid) begin
            r_is_irq  <= 1'b0;
            r_is_mret <= 1'b1;
            r_cause   <= 5'd0;
            r_pc      <= '0;
            r_tval    <= '0;
          end
        end
        S_RD_MSTATUS:         r_ms     <= csr_val;
        S_RD_MTVEC, S_RD_MEPC: r_target <= w_target;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    csr_index      = 12'h000;
    csr_opcode     = c_op_nop;
    csr_ren        = 1'b0;
    csr_wen        = 1'b0;
    csr_reg_val    = '0;
    redirect_valid = 1'b0;
    trap_ack       = 1'b0;
    redirect_pc    = '0;
    case (r_state)
      S_IDLE: begin
        if (exc_valid || irq_valid || mret_valid) w_state_nxt = S_RD_MSTATUS;
      end
      S_RD_MSTATUS: begin
        csr_index   = c_addr_mstatus;
        csr_opcode  = c_op_csrrs;
        csr_ren     = 1'b1;
        w_state_nxt = S_WR_MSTATUS;
      end
      S_WR_MSTATUS: begin
        csr_index   = c_addr_mstatus;
        csr_opcode  = c_op_csrrw;
        csr_wen     = 1'b1;
        csr_reg_val = r_is_mret ? w_ms_mret : w_ms_trap;
        w_state_nxt = r_is_mret ? S_RD_MEPC : S_WR_MEPC;
      end
      S_WR_MEPC: begin
        csr_index   = c_addr_mepc;
        csr_opcode  = c_op_csrrw;
        csr_wen     = 1'b1;
        csr_reg_val = r_pc;
        w_state_nxt = S_WR_MCAUSE;
      end
      S_WR_MCAUSE: begin
        csr_index   = c_addr_mcause;
        csr_opcode  = c_op_csrrw;
        csr_wen     = 1'b1;
        csr_reg_val = w_mcause;
        w_state_nxt = S_WR_MTVAL;
      end
      S_WR_MTVAL: begin
        csr_index   = c_addr_mtval;
        csr_opcode  = c_op_csrrw;
        csr_wen     = 1'b1;
        csr_reg_val = r_tval;
        w_state_nxt = S_RD_MTVEC;
      end
      S_RD_MTVEC: begin
        csr_index   = c_addr_mtvec;
        csr_opcode  = c_op_csrrs;
        csr_ren     = 1'b1;
        w_state_nxt = S_REDIRECT;
      end
      S_RD_MEPC: begin
        csr_index   = c_addr_mepc;
        csr_opcode  = c_op_csrrs;
        csr_ren     = 1'b1;
        w_state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        trap_ack       = 1'b1;
        redirect_pc    = r_target;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Machine-mode trap sequencer that sits directly upstream of the CSR unit. It drives the CSR command/input port on behalf of the pipeline.
- On an exception, interrupt or MRET it performs the required CSR reads and writes, one access per cycle. It then issues a single-cycle PC redirect to fetch.
- It stalls the pipeline for the whole sequence.

Parameters:
- XLEN, 32, data/address width.
- VECTORED_EN, 1, 1 = honour mtvec.MODE=1 (vectored interrupts); 0 = always direct.

Ports:
- clk  in  1  core clock
- nrst  in  1  asynchronous active-low reset
- exc_valid  in  1  synchronous exception request; held until trap_ack
- exc_cause  in  5  exception code
- exc_pc  in  XLEN  PC of faulting instruction
- exc_tval  in  XLEN  trap value (bad address/instruction)
- irq_valid  in  1  interrupt request, already gated by mstatus.MIE/mie upstream; held until trap_ack
- irq_cause  in  5  interrupt code
- irq_pc  in  XLEN  PC to resume at after the interrupt
- mret_valid  in  1  MRET retiring; held until trap_ack
- trap_ack  out  1  one-cycle pulse, coincident with redirect_valid
- busy  out  1  pipeline stall; high whenever state != IDLE
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  XLEN  redirect target
- csr_index  out  12  CSR address to the CSR unit
- csr_opcode  out  3  funct3 encoding: CSRRW=001, CSRRS=010, 000 = no-op
- csr_ren  out  1  CSR read enable
- csr_wen  out  1  CSR write enable
- csr_reg_val  out  XLEN  write data
- csr_val  in  XLEN  combinational old-value readback from the CSR unit

Behaviour:
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343.
- CSR unit timing: reads are combinational in the same cycle; writes land at the next clk edge.
- Reset (nrst low, any time, including mid-sequence):
  - state goes to IDLE and all outputs are 0.
  - Internal latches (kind, cause, pc, tval, mstatus copy) are cleared.
  - An in-flight sequence is abandoned with no ack.
- IDLE:
  - CSR outputs are csr_opcode=000, ren=wen=0, reg_val=0.
  - Each cycle, sample requests with priority exc_valid > irq_valid > mret_valid.
  - Latch the winner's kind, cause, pc and tval, then go to RD_MSTATUS.
  - For an interrupt, tval is latched as 0. The pc is latched with bits [1:0] cleared.
- Requests arriving while busy are ignored and not acked. Sources must hold them.
- Trap states (exception or interrupt), one CSR access per cycle:
  1. RD_MSTATUS: index=0x300, CSRRS, ren=1, wen=0, reg_val=0. Capture csr_val into ms.
  2. WR_MSTATUS: CSRRW, wen=1, ren=0. Data = ms with MPIE[7]=ms[3], MIE[3]=0, MPP[12:11]=2'b11.
  3. WR_MEPC: CSRRW to 0x341, data = latched pc.
  4. WR_MCAUSE: CSRRW to 0x342, data = {is_irq, 26'b0, cause}.
  5. WR_MTVAL: CSRRW to 0x343, data = latched tval.
  6. RD_MTVEC: CSRRS to 0x305, ren=1, wen=0. Compute the target:
     - base = csr_val & ~3.
     - If VECTORED_EN, is_irq and csr_val[1:0]==01: target = base + (cause<<2).
     - Otherwise target = base.
     - Register the target.
  7. REDIRECT: redirect_valid=1, trap_ack=1, redirect_pc=target, CSR no-op. Next state is IDLE.
- MRET states:
  1. RD_MSTATUS: as above.
  2. WR_MSTATUS: data = ms with MIE[3]=ms[7], MPIE[7]=1, MPP=2'b11.
  3. RD_MEPC: CSRRS to 0x341, ren=1, wen=0. Target = csr_val & ~3.
  4. REDIRECT: as above.
- Latency, with the request sampled in IDLE at cycle 0:
  - Trap: redirect at cycle 7.
  - MRET: redirect at cycle 4.
  - busy is high from cycle 1 through the REDIRECT cycle inclusive; it is low again in the following IDLE cycle.
- Back-to-back: if a request is present in the IDLE cycle right after REDIRECT, it starts immediately. The minimum gap is 1 IDLE cycle.
- No arithmetic overflow handling: base + (cause<<2) wraps modulo 2^XLEN.

Test Plan:
- Reset, then exc_valid with cause=2, pc=0x0000_1006, tval=0xDEAD_BEEF, mtvec=0x0000_0100, mstatus=0x8:
  - mepc=0x1004, mcause=0x2, mtval=0xDEADBEEF, mstatus=0x1880.
  - redirect_pc=0x100 at cycle 7; trap_ack is a single pulse.
- irq_valid with cause=7, mtvec=0x0000_0201, VECTORED_EN=1:
  - mcause=0x8000_0007, mtval=0, redirect_pc=0x21C.
  - With VECTORED_EN=0: redirect_pc=0x200.
- mret_valid with mepc=0x0000_2000, mstatus=0x1880:
  - mstatus becomes 0x1888; redirect_pc=0x2000 at cycle 4; busy high for cycles 1-4.
- exc_valid, irq_valid and mret_valid asserted together:
  - The exception is serviced first and acked; irq/mret are not acked.
  - The irq then starts on the IDLE cycle following the REDIRECT.
- nrst pulsed low during WR_MCAUSE:
  - All outputs are 0 immediately.
  - mcause in the CSR unit is not updated by the controller; no trap_ack or redirect occurs.
  - After release, the still-held exc_valid restarts the full 7-cycle sequence.
- A new exc_valid raised mid-sequence (while busy) is ignored until IDLE. It is then serviced with its own latched values.
